// File: rtl/msx_mouse_pkg.sv
// msx_mouse_pkg: phase type, HPS packet bit positions and saturation helpers
package msx_mouse_pkg;

    typedef enum logic [1:0] {P_XH, P_XL, P_YH, P_YL} phase_t;

    localparam int PKT_TOG = 24;
    localparam int Y_MSB   = 23;
    localparam int Y_LSB   = 16;
    localparam int X_MSB   = 15;
    localparam int X_LSB   = 8;
    localparam int Y_SIGN  = 5;
    localparam int X_SIGN  = 4;
    localparam int BTN_R   = 1;
    localparam int BTN_L   = 0;

    function automatic int sat_add(input int a, input int b, input int w);
        int lim, s;
        lim = (1 << (w - 1)) - 1;
        s = a + b;
        return s > lim ? lim : s < -lim ? -lim : s;
    endfunction

    function automatic logic [7:0] clamp8(input int v);
        return 8'(sat_add(v, 0, 8));
    endfunction

endpackage

// File: rtl/msx_mouse_port_if.sv
// msx_mouse_port_if: HPS mouse packet in, MSX joystick-port strobe and pins
interface msx_mouse_port_if;
    logic [24:0] ps2_mouse;
    logic        strobe;
    logic [5:0]  data;
    modport master (output ps2_mouse, output strobe, input data);
    modport slave  (input ps2_mouse, input strobe, output data);
endinterface

// File: rtl/msx_mouse_port.sv
// msx_mouse_port: PS/2 mouse packets to MSX port nibble protocol with saturating accumulators
module msx_mouse_port import msx_mouse_pkg::*; #(
    parameter int TIMEOUT_CYC = 32000,
    parameter int ACC_W       = 10
) (
    input logic             clk_sys,
    input logic             reset,
    msx_mouse_port_if.slave port
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    phase_t                  phase, phase_nx;
    logic signed [ACC_W-1:0] acc_x, acc_y, acc_x_nx, acc_y_nx;
    logic signed [7:0]       snap_x, snap_y;
    logic [CNT_W-1:0]        idle;
    logic                    pkt_q, strobe_q, btn_l, btn_r;
    logic                    pkt, strb_edge, leave, timeout;
    logic [3:0]              nib;
    int                      dx, dy, sub_x, sub_y;

    always_comb begin
        pkt       = port.ps2_mouse[PKT_TOG] ^ pkt_q;
        strb_edge = port.strobe ^ strobe_q;
        timeout   = idle == CNT_W'(TIMEOUT_CYC);
        leave     = strb_edge && phase == P_XH;
        phase_nx  = strb_edge ? phase_t'(phase + 2'd1) : timeout ? P_XH : phase;
        dx        = pkt ? int'($signed({port.ps2_mouse[X_SIGN], port.ps2_mouse[X_MSB:X_LSB]})) : 0;
        dy        = pkt ? int'($signed({port.ps2_mouse[Y_SIGN], port.ps2_mouse[Y_MSB:Y_LSB]})) : 0;
        sub_x     = leave ? int'(snap_x) : 0;
        sub_y     = leave ? int'(snap_y) : 0;
        // MSX X grows leftwards, so PS/2 X is subtracted; snapshot and packet fold into one saturation
        acc_x_nx  = ACC_W'(sat_add(int'(acc_x) - sub_x, -dx, ACC_W));
        acc_y_nx  = ACC_W'(sat_add(int'(acc_y) - sub_y, dy, ACC_W));
        nib       = phase == P_XH ? snap_x[7:4] : phase == P_XL ? snap_x[3:0] :
                    phase == P_YH ? snap_y[7:4] : snap_y[3:0];
    end

    always_ff @(posedge clk_sys) begin
        pkt_q    <= port.ps2_mouse[PKT_TOG];
        strobe_q <= port.strobe;
        if (reset) begin
            phase     <= P_XH;
            acc_x     <= '0;
            acc_y     <= '0;
            snap_x    <= '0;
            snap_y    <= '0;
            idle      <= '0;
            btn_l     <= 1'b0;
            btn_r     <= 1'b0;
            port.data <= 6'b11_0000;
        end else begin
            phase     <= phase_nx;
            idle      <= strb_edge ? '0 : timeout ? idle : idle + 1'b1;
            acc_x     <= acc_x_nx;
            acc_y     <= acc_y_nx;
            if (phase == P_XH && !strb_edge) begin
                snap_x <= clamp8(int'(acc_x));
                snap_y <= clamp8(int'(acc_y));
            end
            if (pkt) begin
                btn_l <= port.ps2_mouse[BTN_L];
                btn_r <= port.ps2_mouse[BTN_R];
            end
            port.data <= {~btn_r, ~btn_l, nib};
        end
    end

endmodule

// File: tb/tb_msx_mouse_port.sv
// tb_msx_mouse_port: directed checks of packet intake, nibble readout, saturation, timeout and buttons
module tb_msx_mouse_port;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    logic tog     = 1'b0;
    int   total   = 0;
    int   passed  = 0;

    msx_mouse_port_if bus ();

    msx_mouse_port dut (
        .clk_sys(clk_sys),
        .reset  (reset),
        .port   (bus.slave)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic send(input int x, input int y, input logic [1:0] btn);
        logic [8:0] x9, y9;
        x9  = 9'(x);
        y9  = 9'(y);
        tog = ~tog;
        bus.ps2_mouse = {tog, y9[7:0], x9[7:0], 2'b00, y9[8], x9[8], 2'b00, btn};
        wait_n(1);
    endtask

    task automatic toggle();
        bus.strobe = ~bus.strobe;
        wait_n(3);
    endtask

    task automatic read4(input string tag, input logic [15:0] nibs);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s[%0d]", tag, i), {2'b00, bus.data[3:0]}, {2'b00, nibs[15-4*i -: 4]});
            toggle();
        end
    endtask

    initial begin
        bus.ps2_mouse = '0;
        bus.strobe    = 1'b0;
        wait_n(4);
        chk("reset_data", bus.data, 6'h30);
        reset = 1'b0;
        wait_n(2);
        chk("reset_idle", bus.data, 6'h30);
        read4("reset_read", 16'h0000);

        send(5, 3, 2'b00);
        wait_n(4);
        read4("move", 16'hFB03);
        read4("move_clr", 16'h0000);

        send(-100, 0, 2'b00);
        send(-100, 0, 2'b00);
        send(-100, 0, 2'b00);
        wait_n(4);
        read4("sat1", 16'h7F00);
        read4("sat2", 16'h7F00);
        read4("sat3", 16'h2E00);
        read4("sat_clr", 16'h0000);

        send(0, 0, 2'b01);
        chk("btn_lat", bus.data, 6'h30);
        wait_n(1);
        chk("btn_left", bus.data, 6'h20);
        send(0, 0, 2'b10);
        wait_n(1);
        chk("btn_right", bus.data, 6'h10);
        send(0, 0, 2'b00);
        wait_n(1);
        chk("btn_none", bus.data, 6'h30);

        send(-20, 0, 2'b00);
        wait_n(4);
        chk("sim_xh", bus.data, 6'h31);
        bus.strobe = ~bus.strobe;
        send(-10, 0, 2'b00);
        chk("sim_lat1", bus.data, 6'h31);
        wait_n(1);
        chk("sim_xl", bus.data, 6'h34);
        wait_n(1);
        toggle();
        chk("sim_yh", bus.data, 6'h30);
        toggle();
        chk("sim_yl", bus.data, 6'h30);
        toggle();
        read4("sim_res", 16'h0A00);

        chk("to_xh0", bus.data, 6'h30);
        toggle();
        chk("to_xl0", bus.data, 6'h30);
        toggle();
        send(16, 33, 2'b00);
        wait_n(4);
        chk("to_hold", bus.data, 6'h30);
        wait_n(32000 + 4);
        chk("to_xh", bus.data, 6'h3F);
        read4("to_read", 16'hF021);
        read4("to_clr", 16'h0000);

        send(-50, -60, 2'b00);
        wait_n(4);
        chk("rst_mid_xh", bus.data, 6'h33);
        toggle();
        chk("rst_mid_xl", bus.data, 6'h32);
        reset = 1'b1;
        wait_n(2);
        reset = 1'b0;
        wait_n(3);
        chk("rst_mid_data", bus.data, 6'h30);
        read4("rst_mid_read", 16'h0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
